// File: rtl/dp_probe_tap.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dp_probe_tap                                               |
// | Description : Triggered capture tap. Timestamped samples go into a FIFO  |
// |               that a reader drains through a valid/ready head port.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dp_probe_tap #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] probe_data,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [7:0]        post_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TS_W-1:0]   out_ts,
    output logic [1:0]        state,
    output logic              overflow
);

    localparam int c_addr_w  = $clog2(DEPTH);
    localparam int c_ptr_w   = c_addr_w + 1;
    localparam int c_entry_w = DATA_W + TS_W;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_armed   = 2'd1;
    localparam logic [1:0] c_st_capture = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    logic [TS_W-1:0]      r_ts;
    logic [1:0]           r_state;
    logic [7:0]           r_remaining;
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic [TS_W-1:0]      r_out_ts;
    logic                 r_overflow;
    logic [c_entry_w-1:0] r_mem [DEPTH];

    logic                 w_hit;
    logic                 w_start;
    logic                 w_push_req;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic [c_ptr_w-1:0]   w_rptr_nxt;
    logic [c_ptr_w-1:0]   w_wptr_nxt;
    logic                 w_nonempty_nxt;
    logic [c_entry_w-1:0] w_entry;
    logic [c_entry_w-1:0] w_head;
    logic [7:0]           w_post_m1;

    assign w_hit      = (((probe_data ^ trig_value) & trig_mask) == '0);
    assign w_start    = arm && !abort && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_push_req = !abort && (((r_state == c_st_armed) && w_hit) || (r_state == c_st_capture));
    assign w_full     = (r_wptr[c_addr_w] != r_rptr[c_addr_w]) &&
                        (r_wptr[c_addr_w-1:0] == r_rptr[c_addr_w-1:0]);
    assign w_pop      = r_out_valid && out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_rptr_nxt = r_rptr + c_ptr_w'(w_pop);
    assign w_wptr_nxt = r_wptr + c_ptr_w'(w_push);
    assign w_nonempty_nxt = (w_rptr_nxt != w_wptr_nxt);
    assign w_entry    = {probe_data, r_ts};
    // When the next head is the slot being written now, bypass the memory.
    assign w_head     = (w_rptr_nxt == r_wptr) ? w_entry : r_mem[w_rptr_nxt[c_addr_w-1:0]];
    assign w_post_m1  = (post_count == 8'd0) ? 8'd0 : (post_count - 8'd1);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ts    = r_out_ts;
    assign state     = r_state;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_addr_w-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts        <= '0;
            r_state     <= c_st_idle;
            r_remaining <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ts    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_ts <= r_ts + TS_W'(1);

            if (w_start) begin
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_out_valid <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                r_wptr      <= w_wptr_nxt;
                r_rptr      <= w_rptr_nxt;
                r_out_valid <= w_nonempty_nxt;
                if (w_nonempty_nxt) begin
                    r_out_data <= w_head[c_entry_w-1:TS_W];
                    r_out_ts   <= w_head[TS_W-1:0];
                end
                if (w_push_req && !w_push) begin
                    r_overflow <= 1'b1;
                end
            end

            if (abort) begin
                r_state <= c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (arm) r_state <= c_st_armed;
                    end
                    c_st_armed: begin
                        if (w_hit) begin
                            r_remaining <= w_post_m1;
                            r_state     <= (w_post_m1 == 8'd0) ? c_st_done : c_st_capture;
                        end
                    end
                    c_st_capture: begin
                        r_remaining <= r_remaining - 8'd1;
                        if (r_remaining <= 8'd1) r_state <= c_st_done;
                    end
                    c_st_done: begin
                        if (arm) r_state <= c_st_armed;
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_probe_tap.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dp_probe_tap                                            |
// | Description : Directed vector table plus hand sequences for dp_probe_tap.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dp_probe_tap;

    localparam int DW = 32;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] probe_data = '0;
    logic [DW-1:0] trig_mask = '0;
    logic [DW-1:0] trig_value = '0;
    logic [7:0]    post_count = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_ts;
    logic [1:0]    state;
    logic          overflow;

    dp_probe_tap #(.DATA_W(DW), .DEPTH(8), .TS_W(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .abort      (abort),
        .probe_data (probe_data),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .post_count (post_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ts     (out_ts),
        .state      (state),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference free-running cycle counter.
    logic [TW-1:0] tb_ts;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 16'd1;
    end

    typedef struct {
        logic        arm;
        logic        abort;
        logic [31:0] probe;
        logic [31:0] mask;
        logic [31:0] value;
        logic [7:0]  pc;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        int          eto;
        logic [1:0]  es;
        logic        eo;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ed [20];
    logic [15:0] et [20];
    logic [15:0] base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic a, input logic ab, input logic [31:0] p,
                        input logic [31:0] m, input logic [31:0] v, input logic [7:0] pc,
                        input logic r, input logic ev, input logic [31:0] edv, input int eto,
                        input logic [1:0] es, input logic eo);
        tbl[i].arm = a;  tbl[i].abort = ab; tbl[i].probe = p;  tbl[i].mask = m;
        tbl[i].value = v; tbl[i].pc = pc;   tbl[i].rdy = r;    tbl[i].ev = ev;
        tbl[i].ed = edv; tbl[i].eto = eto;  tbl[i].es = es;    tbl[i].eo = eo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //    i  arm ab probe          mask           value   pc    rdy ev  exp_data       ts  st   ov
        setv( 0, 1, 0, 32'h0,         32'hFF,        32'h5A, 8'd3, 1, 0, 32'h0,          0, 2'd1, 0);
        setv( 1, 0, 0, 32'h11,        32'hFF,        32'h5A, 8'd3, 1, 0, 32'h0,          0, 2'd1, 0);
        setv( 2, 0, 0, 32'h5A,        32'hFF,        32'h5A, 8'd3, 1, 1, 32'h5A,         2, 2'd2, 0);
        setv( 3, 0, 0, 32'h12345601,  32'hFF,        32'h5A, 8'd3, 1, 1, 32'h12345601,   3, 2'd2, 0);
        setv( 4, 0, 0, 32'h2,         32'hFF,        32'h5A, 8'd3, 1, 1, 32'h2,          4, 2'd3, 0);
        setv( 5, 0, 0, 32'h5A,        32'hFF,        32'h5A, 8'd3, 1, 0, 32'h0,          0, 2'd3, 0);
        setv( 6, 0, 0, 32'h0,         32'hFF,        32'h5A, 8'd3, 0, 0, 32'h0,          0, 2'd3, 0);
        setv( 7, 1, 0, 32'h0,         32'h0,         32'h5A, 8'd0, 0, 0, 32'h0,          0, 2'd1, 0);
        setv( 8, 0, 0, 32'hDEADBEEF,  32'h0,         32'h5A, 8'd0, 0, 1, 32'hDEADBEEF,   8, 2'd3, 0);
        setv( 9, 0, 0, 32'h5A,        32'h0,         32'h5A, 8'd0, 0, 1, 32'hDEADBEEF,   8, 2'd3, 0);
        setv(10, 0, 0, 32'h0,         32'h0,         32'h5A, 8'd0, 1, 0, 32'h0,          0, 2'd3, 0);
        setv(11, 1, 0, 32'h0,         32'hFF,        32'h5A, 8'd2, 0, 0, 32'h0,          0, 2'd1, 0);
        setv(12, 0, 0, 32'h15A,       32'hFF,        32'h5A, 8'd2, 0, 1, 32'h15A,       12, 2'd2, 0);
        setv(13, 0, 0, 32'h77,        32'hFF,        32'h5A, 8'd50,0, 1, 32'h15A,       12, 2'd3, 0);
        setv(14, 1, 0, 32'h0,         32'hFF,        32'h5A, 8'd50,0, 0, 32'h0,          0, 2'd1, 0);
        setv(15, 0, 1, 32'h0,         32'hFF,        32'h5A, 8'd50,0, 0, 32'h0,          0, 2'd0, 0);
        setv(16, 1, 1, 32'h0,         32'hFF,        32'h5A, 8'd50,0, 0, 32'h0,          0, 2'd0, 0);
        setv(17, 0, 0, 32'h5A,        32'hFF,        32'h5A, 8'd50,0, 0, 32'h0,          0, 2'd0, 0);

        // Reset state, then release so the first vector's arm lands on the first edge.
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset state",     {30'b0, state},     32'd0);
        chk("reset overflow",  {31'b0, overflow},  32'd0);
        chk("reset out_data",  out_data,           32'd0);
        chk("reset out_ts",    {16'b0, out_ts},    32'd0);
        reset = 1'b0;

        base = tb_ts;
        for (int i = 0; i < NV; i++) begin
            arm = tbl[i].arm; abort = tbl[i].abort; probe_data = tbl[i].probe;
            trig_mask = tbl[i].mask; trig_value = tbl[i].value;
            post_count = tbl[i].pc; out_ready = tbl[i].rdy;
            tick();
            chk($sformatf("v%0d state", i),    {30'b0, state},    {30'b0, tbl[i].es});
            chk($sformatf("v%0d valid", i),    {31'b0, out_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("v%0d overflow", i), {31'b0, overflow}, {31'b0, tbl[i].eo});
            if (tbl[i].ev) begin
                chk($sformatf("v%0d data", i), out_data, tbl[i].ed);
                chk($sformatf("v%0d ts", i),   {16'b0, out_ts}, {16'b0, base + 16'(tbl[i].eto)});
            end
        end
        arm = 0; abort = 0; out_ready = 0;

        // Overflow: 12 samples into 8 entries, drain first 8 in order.
        trig_mask = 32'h0; post_count = 8'd12; arm = 1;
        tick();
        arm = 0;
        chk("ovf armed state", {30'b0, state}, 32'd1);
        for (int k = 0; k < 12; k++) begin
            probe_data = 32'hA000_0000 + k; ed[k] = probe_data; et[k] = tb_ts;
            tick();
        end
        chk("ovf state done", {30'b0, state},    32'd3);
        chk("ovf overflow",   {31'b0, overflow}, 32'd1);
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf drain%0d valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("ovf drain%0d data", i),  out_data, ed[i]);
            chk($sformatf("ovf drain%0d ts", i),    {16'b0, out_ts}, {16'b0, et[i]});
            tick();
        end
        chk("ovf empty", {31'b0, out_valid}, 32'd0);
        chk("ovf sticky", {31'b0, overflow}, 32'd1);
        out_ready = 0;

        // Abort two cycles into a long capture.
        post_count = 8'd10; arm = 1;
        tick();
        arm = 0;
        chk("abort arm clears ovf", {31'b0, overflow}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            probe_data = 32'hB000_0000 + k; ed[k] = probe_data; et[k] = tb_ts;
            tick();
        end
        abort = 1; probe_data = 32'hBBBB_BBBB;
        tick();
        abort = 0;
        chk("abort state idle", {30'b0, state}, 32'd0);
        repeat (2) tick();
        chk("abort stays idle", {30'b0, state}, 32'd0);
        chk("abort overflow",   {31'b0, overflow}, 32'd0);
        out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("abort drain%0d valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("abort drain%0d data", i),  out_data, ed[i]);
            chk($sformatf("abort drain%0d ts", i),    {16'b0, out_ts}, {16'b0, et[i]});
            tick();
        end
        chk("abort empty", {31'b0, out_valid}, 32'd0);
        out_ready = 0;

        // Fill the FIFO, then push and pop together while capture continues.
        post_count = 8'd20; arm = 1;
        tick();
        arm = 0;
        for (int k = 0; k < 8; k++) begin
            probe_data = 32'hC0 + k; ed[k] = probe_data; et[k] = tb_ts;
            tick();
        end
        chk("full state capture", {30'b0, state}, 32'd2);
        for (int j = 0; j < 20; j++) begin
            chk($sformatf("full pop%0d valid", j), {31'b0, out_valid}, 32'd1);
            chk($sformatf("full pop%0d data", j),  out_data, ed[j]);
            chk($sformatf("full pop%0d ts", j),    {16'b0, out_ts}, {16'b0, et[j]});
            if (j + 8 < 20) begin
                probe_data = 32'hC8 + j; ed[j+8] = probe_data; et[j+8] = tb_ts;
            end
            out_ready = 1;
            tick();
        end
        chk("full empty",    {31'b0, out_valid}, 32'd0);
        chk("full overflow", {31'b0, overflow},  32'd0);
        chk("full done",     {30'b0, state},     32'd3);
        out_ready = 0;

        // Asynchronous reset mid-capture, then a clean session.
        post_count = 8'd10; arm = 1;
        tick();
        arm = 0; probe_data = 32'hD0;
        tick();
        probe_data = 32'hD1;
        tick();
        chk("rst pre valid", {31'b0, out_valid}, 32'd1);
        #3 reset = 1;
        #1;
        chk("rst async valid", {31'b0, out_valid}, 32'd0);
        chk("rst async state", {30'b0, state},     32'd0);
        chk("rst async data",  out_data,           32'd0);
        tick();
        reset = 0;
        repeat (2) tick();
        chk("rst stays idle",  {30'b0, state},     32'd0);
        chk("rst stays empty", {31'b0, out_valid}, 32'd0);
        trig_mask = 32'hFF; trig_value = 32'h5A; post_count = 8'd1; arm = 1;
        tick();
        arm = 0; probe_data = 32'h33;
        tick();
        probe_data = 32'h5A; et[0] = tb_ts;
        tick();
        chk("rearm state", {30'b0, state},     32'd3);
        chk("rearm valid", {31'b0, out_valid}, 32'd1);
        chk("rearm data",  out_data,           32'h5A);
        chk("rearm ts",    {16'b0, out_ts},    {16'b0, et[0]});
        chk("rearm ovf",   {31'b0, overflow},  32'd0);
        out_ready = 1;
        tick();
        chk("rearm empty", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dp_probe_tap.md
DP_PROBE_TAP -- requirements
Module: dp_probe_tap

Interface
REQ-001 Parameter DATA_W, default 32, width of the probed signal vector.
REQ-002 Parameter DEPTH, default 8, capture FIFO entries; power of two, 2..64.
REQ-003 Parameter TS_W, default 16, timestamp counter width.
REQ-004 Port clk  in  1  sole clock; all state on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port arm  in  1  single-cycle pulse; starts a capture session from IDLE or DONE.
REQ-007 Port abort  in  1  single-cycle pulse; returns FSM to IDLE from any state.
REQ-008 Port probe_data  in  DATA_W  design signals sampled every cycle.
REQ-009 Port trig_mask  in  DATA_W  bits participating in the trigger compare.
REQ-010 Port trig_value  in  DATA_W  trigger compare value.
REQ-011 Port post_count  in  8  samples to capture after trigger, inclusive of the trigger sample; 0 treated as 1.
REQ-012 Port out_valid  out  1  FIFO head entry available to the probe-side reader.
REQ-013 Port out_ready  in  1  reader accepts the head entry.
REQ-014 Port out_data  out  DATA_W  captured sample at FIFO head.
REQ-015 Port out_ts  out  TS_W  timestamp of the head sample.
REQ-016 Port state  out  2  FSM encoding: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-017 Port overflow  out  1  sticky; a capture was dropped because the FIFO was full.

Function
REQ-018 Free-running timestamp counter ts increments by 1 each cycle and wraps modulo 2^TS_W.
REQ-019 Trigger hit is defined as ((probe_data ^ trig_value) & trig_mask) == 0; an all-zero mask hits immediately.
REQ-020 IDLE->ARMED on arm; ARMED->CAPTURE on trigger hit; CAPTURE->DONE when the remaining sample count reaches 0; DONE->ARMED on arm.
REQ-021 On the ARMED-cycle hit, that same cycle's probe_data and ts are written to the FIFO (trigger sample), and remaining = max(post_count,1) - 1 is latched.
REQ-022 In CAPTURE, one sample per cycle {probe_data, ts} is written and remaining is decremented; the transition to DONE occurs on the cycle the last sample is written.
REQ-023 post_count is sampled only at the trigger; later changes do not affect the session.
REQ-024 A write while the FIFO is full (after any same-cycle pop) is dropped, sets overflow, and still decrements remaining.
REQ-025 FIFO pop occurs when out_valid && out_ready; out_data/out_ts are registered head values, stable while out_valid=1 and out_ready=0.
REQ-026 Simultaneous push and pop on a full FIFO succeeds without overflow; on an empty FIFO the new entry appears with out_valid=1 the next cycle (write-to-read latency 1 cycle).
REQ-027 abort takes priority over arm and trigger: FSM returns to IDLE next cycle and no further writes occur; FIFO contents are kept and remain drainable.
REQ-028 arm clears overflow and flushes the FIFO (out_valid=0 the next cycle); arm in ARMED or CAPTURE is ignored.
REQ-029 Read and write pointers are log2(DEPTH)+1 bits with wrap bit; full/empty derived from pointer compare.

Reset
REQ-030 On reset assertion, immediately: state=IDLE, out_valid=0, overflow=0, out_data=0, out_ts=0, ts=0, FIFO pointers=0, remaining=0.
REQ-031 Reset asserted mid-CAPTURE discards the session; after deassertion the block stays in IDLE until arm.
REQ-032 arm/abort pulses coincident with the first clock edge after deassertion are honoured normally.

Verification
REQ-033 mask=0x000000FF, value=0x5A, post_count=3, out_ready=1; arm, drive 0x5A at cycle T -> three entries with ts T, T+1, T+2, state DONE at T+3.
REQ-034 DEPTH=8, post_count=12, out_ready=0 -> 8 entries held, overflow=1, state DONE; draining yields first 8 samples in order.
REQ-035 post_count=0 -> exactly one entry (the trigger sample), DONE the cycle after the hit.
REQ-036 abort two cycles into a post_count=10 capture -> state IDLE, exactly 2 entries (trigger + 1) drainable, overflow=0.
REQ-037 Full FIFO with out_ready=1 during CAPTURE -> push and pop each cycle, no overflow, order preserved.
REQ-038 Reset pulse during CAPTURE -> out_valid=0, state=IDLE asynchronously; re-arm produces a clean session.
